// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit (MAR/MDR path,
// I/O decode and SRAM read/write sequencer).
package mau_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        DONE,
        ERR
    } mau_state_t;

    localparam int          CNT_W       = 5;
    localparam logic [15:0] IO_BASE_DEF = 16'hFE00;

    // Wait counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mau_seq.sv
// Read/write sequencer with wait-state counter for the memory access unit.
// Optional timeout to ERR is built when MAU_TIMEOUT_EN is defined; otherwise
// WAIT holds until mem_ready and err_o is tied low.
//
// state | meaning
// IDLE  | waiting for req_rd/req_wr, no enables
// SETUP | one cycle, CE plus OE (read) or WE (write), counter cleared
// WAIT  | enables held, counter counts up until wait states met and ready
// DONE  | one-cycle done pulse, enables dropped
// ERR   | timeout hit, enables dropped, sticky err set, back to IDLE
module mau_seq
    import mau_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 31
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic req_rd_i,
    input  logic req_wr_i,
    input  logic mem_ready_i,
    output logic mem_ce_o,
    output logic mem_we_o,
    output logic mem_oe_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
    output logic rd_cap_o
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mau_seq: WAIT_STATES out of range 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
        $error("mau_seq: TIMEOUT out of range 1..31");
    end

    localparam logic [CNT_W-1:0] WS_C = CNT_W'(WAIT_STATES);

    mau_state_t       state_q;
    logic             is_rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ce_q, we_q, oe_q, busy_q, done_q;
    logic             wait_met;

`ifdef MAU_TIMEOUT_EN
    // Leaving WAIT on the edge that ends the TIMEOUT-th WAIT cycle.
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TIMEOUT - 1);
    logic err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign wait_met = mem_ready_i && (cnt_q >= WS_C);

    // MDR capture strobe for the parent, valid on the edge that leaves WAIT.
    assign rd_cap_o = (state_q == WAIT) && is_rd_q && wait_met;

    assign mem_ce_o = ce_q;
    assign mem_we_o = we_q;
    assign mem_oe_o = oe_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

    // Sequencer state, wait counter and registered memory-side outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (req_rd_i || req_wr_i) begin
                        state_q <= SETUP;
                        is_rd_q <= req_rd_i;
                        ce_q    <= 1'b1;
                        oe_q    <= req_rd_i;
                        we_q    <= !req_rd_i;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= sat_inc(cnt_q);
                    if (wait_met) begin
                        state_q <= DONE;
                        ce_q    <= 1'b0;
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
`ifdef MAU_TIMEOUT_EN
                    else if (cnt_q >= TO_LAST_C) begin
                        state_q <= ERR;
                        ce_q    <= 1'b0;
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        err_q   <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ce_q    <= 1'b0;
                    we_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers, zero-extended memory address,
// memory-mapped I/O decode and the read/write sequencer (mau_seq).
// Build option: define MAU_TIMEOUT_EN to enable the WAIT timeout / ERR path.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 20,
    parameter int                WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] IO_BASE     = DATA_W'(IO_BASE_DEF),
    parameter int                TIMEOUT     = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              mem_oe,
    output logic              io_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic              rd_cap;

    mau_seq #(
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_seq (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_rd_i    (req_rd),
        .req_wr_i    (req_wr),
        .mem_ready_i (mem_ready),
        .mem_ce_o    (mem_ce),
        .mem_we_o    (mem_we),
        .mem_oe_o    (mem_oe),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .rd_cap_o    (rd_cap)
    );

    // MAR loads from the bus only while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mar_q <= '0;
        end else if (!busy && ld_mar) begin
            mar_q <= bus_in;
        end
    end

    // MDR takes read data at the end of a read, otherwise the bus when idle
    // and mio_en is low; ld_mdr with mio_en high in IDLE does nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdr_q <= '0;
        end else if (rd_cap) begin
            mdr_q <= io_sel ? io_rdata : mem_rdata;
        end else if (!busy && ld_mdr && !mio_en) begin
            mdr_q <= bus_in;
        end
    end

    assign mar_out     = mar_q;
    assign mdr_out     = mdr_q;
    assign mem_address = ADDR_W'(mar_q);
    assign mem_wdata   = mdr_q;
    assign io_sel      = (mar_q >= IO_BASE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=16, ADDR_W=20, WAIT_STATES=2).
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, req_rd, req_wr, mem_ready;
    logic [15:0] mem_rdata, io_rdata;
    logic [15:0] mar_out, mdr_out, mem_wdata;
    logic [19:0] mem_address;
    logic        mem_ce, mem_we, mem_oe, io_sel, busy, done, err;

    int n_vec = 0;
    int n_mis = 0;

    mem_access_unit #(
        .DATA_W      (16),
        .ADDR_W      (20),
        .WAIT_STATES (2),
        .IO_BASE     (16'hFE00),
        .TIMEOUT     (31)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_in      (bus_in),
        .ld_mar      (ld_mar),
        .ld_mdr      (ld_mdr),
        .mio_en      (mio_en),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .mem_rdata   (mem_rdata),
        .io_rdata    (io_rdata),
        .mem_ready   (mem_ready),
        .mar_out     (mar_out),
        .mdr_out     (mdr_out),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe),
        .io_sel      (io_sel),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one access with req held for the first edge only; mem_ready is
    // high from step ready_at on. Counts per-step enable activity.
    task automatic run_access(input logic rd, input logic wr, input int ready_at,
                              input logic [15:0] exp_wdata,
                              output int done_at, output int oe_cnt, output int we_cnt,
                              output int done_cnt, output int wd_bad);
        done_at  = 0;
        oe_cnt   = 0;
        we_cnt   = 0;
        done_cnt = 0;
        wd_bad   = 0;
        req_rd   = rd;
        req_wr   = wr;
        for (int i = 1; i <= 20; i++) begin
            mem_ready = (i >= ready_at);
            step();
            req_rd = 1'b0;
            req_wr = 1'b0;
            if (mem_oe) oe_cnt++;
            if (mem_we) begin
                we_cnt++;
                if (mem_wdata !== exp_wdata) wd_bad++;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        mem_ready = 1'b0;
    endtask

    int  d_at, oe_n, we_n, d_n, wd_b;
    int  err_at, idle_at;
    logic seen;

    initial begin
        reset = 1'b1;
        bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0;
        req_rd = 0; req_wr = 0; mem_ready = 0;
        mem_rdata = '0; io_rdata = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_mar", mar_out, 0);
        chk("rst_mdr", mdr_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", {mem_ce, mem_we, mem_oe}, 0);
        reset = 1'b0;
        step();

        // MAR load and zero extension
        bus_in = 16'h3000; ld_mar = 1;
        step();
        ld_mar = 0;
        chk("mar_load", mar_out, 16'h3000);
        chk("mem_addr", mem_address, 20'h03000);
        chk("io_sel_mem", io_sel, 0);

        // memory read, ready held high
        mio_en = 1; mem_rdata = 16'hBEEF;
        run_access(1, 0, 1, 16'h0000, d_at, oe_n, we_n, d_n, wd_b);
        chk("rd_done_at", d_at, 5);
        chk("rd_done_cnt", d_n, 1);
        chk("rd_oe_cnt", oe_n, 4);
        chk("rd_we_cnt", we_n, 0);
        chk("rd_mdr", mdr_out, 16'hBEEF);
        chk("rd_idle", busy, 0);

        // ld_mdr with mio_en=1 in IDLE is ignored
        bus_in = 16'h7777; ld_mdr = 1; mio_en = 1;
        step();
        chk("mdr_mio_hold", mdr_out, 16'hBEEF);

        // MDR from bus, then write with late ready
        bus_in = 16'h1234; mio_en = 0;
        step();
        ld_mdr = 0;
        chk("mdr_load", mdr_out, 16'h1234);
        run_access(0, 1, 6, 16'h1234, d_at, oe_n, we_n, d_n, wd_b);
        chk("wr_done_at", d_at, 6);
        chk("wr_done_cnt", d_n, 1);
        chk("wr_we_cnt", we_n, 5);
        chk("wr_oe_cnt", oe_n, 0);
        chk("wr_wdata", wd_b, 0);
        chk("wr_mdr_keep", mdr_out, 16'h1234);

        // I/O read
        bus_in = 16'hFE04; ld_mar = 1;
        step();
        ld_mar = 0;
        chk("io_sel_io", io_sel, 1);
        io_rdata = 16'h0041; mem_rdata = 16'hFFFF; mio_en = 1;
        run_access(1, 0, 1, 16'h0000, d_at, oe_n, we_n, d_n, wd_b);
        chk("io_done_at", d_at, 5);
        chk("io_mdr", mdr_out, 16'h0041);

        // simultaneous requests: read wins
        bus_in = 16'h3000; ld_mar = 1;
        step();
        ld_mar = 0;
        mem_rdata = 16'hA5A5;
        run_access(1, 1, 1, 16'h0000, d_at, oe_n, we_n, d_n, wd_b);
        chk("both_oe_cnt", oe_n, 4);
        chk("both_we_cnt", we_n, 0);
        chk("both_mdr", mdr_out, 16'hA5A5);

        // ld_mar while in WAIT is ignored
        mem_rdata = 16'h5A5A;
        req_rd = 1;
        step();
        req_rd = 0;
        step();
        step();
        bus_in = 16'h1111; ld_mar = 1;
        step();
        ld_mar = 0;
        chk("mar_busy_hold", mar_out, 16'h3000);
        chk("wait_busy", busy, 1);
        mem_ready = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (done) seen = 1;
        end
        mem_ready = 0;
        chk("wait_done_seen", seen, 1);
        step();

`ifdef MAU_TIMEOUT_EN
        // timeout: 31 WAIT cycles, then ERR, then IDLE one cycle later
        err_at = 0; idle_at = 0; d_n = 0;
        req_rd = 1;
        for (int i = 1; i <= 40; i++) begin
            step();
            req_rd = 0;
            if (done) d_n++;
            if (err && err_at == 0) begin
                err_at = i;
                chk("to_en_off", {mem_ce, mem_oe}, 0);
            end
            if (err_at != 0 && !busy && idle_at == 0) idle_at = i;
        end
        chk("to_err_at", err_at, 33);
        chk("to_idle_at", idle_at, 34);
        chk("to_no_done", d_n, 0);
        chk("to_err_sticky", err, 1);
        chk("to_mdr_keep", mdr_out, 16'h5A5A);
`else
        // no timeout: WAIT holds for as long as ready stays low
        req_rd = 1;
        step();
        req_rd = 0;
        for (int i = 0; i < 40; i++) step();
        chk("hold_busy", busy, 1);
        chk("hold_ce", mem_ce, 1);
        chk("hold_err", err, 0);
        mem_ready = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (done) seen = 1;
        end
        mem_ready = 0;
        chk("hold_done_seen", seen, 1);
        step();
`endif

        // reset in the middle of WAIT
        req_rd = 1;
        step();
        req_rd = 0;
        step();
        step();
        chk("mid_oe_before", mem_oe, 1);
        reset = 1;
        step();
        chk("mid_rst_en", {mem_ce, mem_we, mem_oe}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        reset = 0;
        step();
        chk("mid_no_done", done, 0);
        chk("mid_mar_clr", mar_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
